// File: rtl/enc_input_pkg.sv
// Shared types and constants for the rotary-encoder / push-switch input conditioner.
package enc_input_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_ERR  = 3'd4
   } enc_state_e;

   typedef enum logic {
      DIR_CW  = 1'b0,
      DIR_CCW = 1'b1
   } enc_dir_e;

   localparam int                    STEP_MAG_W   = 4;
   localparam logic [STEP_MAG_W-1:0] STEP_MAG_MAX = 4'd8;
   localparam logic [STEP_MAG_W-1:0] STEP_MAG_ONE = 4'd1;

   localparam logic [1:0] Q_REST = 2'b00;
   localparam logic [1:0] Q_MID  = 2'b11;

   // First code seen after leaving the detent in the given direction.
   function automatic logic [1:0] q_first(input enc_dir_e dir);
      return (dir == DIR_CW) ? 2'b01 : 2'b10;
   endfunction

   // Last code seen before returning to the detent in the given direction.
   function automatic logic [1:0] q_last(input enc_dir_e dir);
      return (dir == DIR_CW) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-switch conditioner: 2-FF synchronizer, tick-gated agreement counter and
// single-cycle press/release pulses. Reusable for any additional button.
module sw_debounce #(
   parameter int DEBOUNCE_TICKS = 1024,
   parameter bit SW_ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic sw_i,
   output logic press_o,
   output logic release_o,
   output logic level_o
);

   localparam int               CNT_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             sw_meta_q, sw_sync_q;
   logic             stable_q, stable_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      stable_d  = stable_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick_i) begin
         if (sw_sync_q == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_d  = sw_sync_q;
            cnt_d     = '0;
            press_d   = sw_sync_q;
            release_d = ~sw_sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         sw_meta_q <= 1'b0;
         sw_sync_q <= 1'b0;
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sw_meta_q <= sw_i ^ SW_ACTIVE_LOW;
         sw_sync_q <= sw_meta_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign press_o   = press_q;
   assign release_o = release_q;
   assign level_o   = stable_q;

endmodule

// File: rtl/enc_input_conditioner.sv
// Encoder and push-switch front end: sync, prescaled sampling, quadrature decode, debounce.
// Optional detent acceleration (step_mag_o doubling) is built when ENC_ACCEL_EN is defined.
module enc_input_conditioner
   import enc_input_pkg::*;
#(
   parameter int SAMPLE_DIV     = 256,
   parameter int DEBOUNCE_TICKS = 1024,
   parameter bit SW_ACTIVE_LOW  = 1'b0,
   parameter int ACCEL_WINDOW   = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            enc_i,
   input  logic                  d_sw_i,
   output logic                  tick_o,
   output logic                  inc_o,
   output logic                  dec_o,
   output logic [STEP_MAG_W-1:0] step_mag_o,
   output logic                  press_o,
   output logic                  release_o,
   output logic                  sw_level_o,
   output logic                  enc_err_o
);

   if (SAMPLE_DIV < 2)     begin : g_bad_div $error("SAMPLE_DIV must be >= 2"); end
   if (DEBOUNCE_TICKS < 1) begin : g_bad_deb $error("DEBOUNCE_TICKS must be >= 1"); end
   if (ACCEL_WINDOW < 1)   begin : g_bad_win $error("ACCEL_WINDOW must be >= 1"); end

   localparam int                 PRESC_W    = $clog2(SAMPLE_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);

   logic               rst_meta_q, rst_sync_q;
   logic [PRESC_W-1:0] presc_q;
   logic               tick_q;
   logic [1:0]         enc_meta_q, enc_sync_q;
   enc_state_e         state_q, state_d;
   enc_dir_e           dir_q, dir_d;
   logic               inc_q, inc_d, dec_q, dec_d, err_q, err_d;

   // Reset asserts immediately but leaves on a clock edge, two flops after the pin.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      if (tick_q) begin
         case (state_q)
            ST_IDLE: begin
               if (enc_sync_q == q_first(DIR_CW)) begin
                  state_d = ST_S1;
                  dir_d   = DIR_CW;
               end else if (enc_sync_q == q_first(DIR_CCW)) begin
                  state_d = ST_S1;
                  dir_d   = DIR_CCW;
               end else if (enc_sync_q == Q_MID) begin
                  state_d = ST_ERR;
               end
            end
            ST_S1: begin
               if (enc_sync_q == Q_MID)                 state_d = ST_S2;
               else if (enc_sync_q == Q_REST)           state_d = ST_IDLE;
               else if (enc_sync_q != q_first(dir_q))   state_d = ST_ERR;
            end
            ST_S2: begin
               if (enc_sync_q == q_last(dir_q))         state_d = ST_S3;
               else if (enc_sync_q == q_first(dir_q))   state_d = ST_S1;
               else if (enc_sync_q == Q_REST)           state_d = ST_ERR;
            end
            ST_S3: begin
               if (enc_sync_q == Q_REST) begin
                  state_d = ST_IDLE;
                  inc_d   = (dir_q == DIR_CW);
                  dec_d   = (dir_q == DIR_CCW);
               end else if (enc_sync_q == Q_MID) begin
                  state_d = ST_S2;
               end else if (enc_sync_q == q_first(dir_q)) begin
                  state_d = ST_ERR;
               end
            end
            ST_ERR:  if (enc_sync_q == Q_REST) state_d = ST_IDLE;
            default: state_d = ST_ERR;
         endcase
      end
   end

   // Staying in ERR (including the reset-time ERR) never re-signals an error.
   assign err_d = (state_d == ST_ERR) && (state_q != ST_ERR);

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         presc_q    <= '0;
         tick_q     <= 1'b0;
         enc_meta_q <= 2'b00;
         enc_sync_q <= 2'b00;
         state_q    <= ST_ERR;
         dir_q      <= DIR_CW;
         inc_q      <= 1'b0;
         dec_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         presc_q    <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
         tick_q     <= (presc_q == PRESC_LAST);
         enc_meta_q <= enc_i;
         enc_sync_q <= enc_meta_q;
         state_q    <= state_d;
         dir_q      <= dir_d;
         inc_q      <= inc_d;
         dec_q      <= dec_d;
         err_q      <= err_d;
      end
   end

`ifdef ENC_ACCEL_EN
   localparam int               GAP_W   = $clog2(ACCEL_WINDOW + 2);
   localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(ACCEL_WINDOW + 1);
   localparam logic [GAP_W-1:0] GAP_WIN = GAP_W'(ACCEL_WINDOW);

   logic [GAP_W-1:0]      gap_q, gap_d, gap_inc;
   enc_dir_e              last_dir_q, last_dir_d;
   logic [STEP_MAG_W-1:0] mag_q, mag_d;

   // gap_inc is the tick distance from the previous detent, saturating just past the window.
   assign gap_inc = (gap_q == GAP_SAT) ? GAP_SAT : gap_q + 1'b1;

   always_comb begin
      gap_d      = gap_q;
      last_dir_d = last_dir_q;
      mag_d      = mag_q;
      if (tick_q) begin
         gap_d = gap_inc;
         if (inc_d || dec_d) begin
            if ((dir_q == last_dir_q) && (gap_inc <= GAP_WIN))
               mag_d = (mag_q == STEP_MAG_MAX) ? STEP_MAG_MAX : {mag_q[STEP_MAG_W-2:0], 1'b0};
            else
               mag_d = STEP_MAG_ONE;
            last_dir_d = dir_q;
            gap_d      = '0;
         end
      end
   end

   // The gap starts saturated so the first detent after reset is always a single step.
   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         gap_q      <= GAP_SAT;
         last_dir_q <= DIR_CW;
         mag_q      <= STEP_MAG_ONE;
      end else begin
         gap_q      <= gap_d;
         last_dir_q <= last_dir_d;
         mag_q      <= mag_d;
      end
   end

   assign step_mag_o = mag_q;
`else
   assign step_mag_o = STEP_MAG_ONE;
`endif

   sw_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .SW_ACTIVE_LOW  (SW_ACTIVE_LOW)
   ) u_sw_debounce (
      .clk       (clk),
      .rst_n     (rst_sync_q),
      .tick_i    (tick_q),
      .sw_i      (d_sw_i),
      .press_o   (press_o),
      .release_o (release_o),
      .level_o   (sw_level_o)
   );

   assign tick_o    = tick_q;
   assign inc_o     = inc_q;
   assign dec_o     = dec_q;
   assign enc_err_o = err_q;

endmodule
